// File: rtl/spu_krf_pkg.sv
// spu_krf_pkg: shared FSM state, default sizes and precharge value for the KRF
package spu_krf_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} krf_state_e;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LANE_W = 64;
  localparam int DEF_LANES = 2;
  localparam logic KRF_PRECHARGE = 1'b0;
endpackage

// File: rtl/spu_krf_lane.sv
// spu_krf_lane: one DEPTH x LANE_W storage lane, synchronous write, registered read (precharged to zero)
module spu_krf_lane
  import spu_krf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANE_W = DEF_LANE_W,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [LANE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [LANE_W-1:0] o_q
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  logic [LANE_W-1:0] r_mem [DEPTH];
  logic [LANE_W-1:0] r_q;
  logic w_rin;
  assign w_rin = {1'b0, i_raddr} < DEPTH_W;
  assign o_q = r_q;
  // write port; the caller only asserts i_we for in-range addresses
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // registered read; out-of-range or idle reads return the precharge value
  always_ff @(posedge clk)
    if (rst) r_q <= {LANE_W{KRF_PRECHARGE}};
    else r_q <= (i_re && w_rin) ? r_mem[i_raddr] : {LANE_W{KRF_PRECHARGE}};
endmodule

// File: rtl/spu_krf_1r1w_param.sv
// spu_krf_1r1w_param: DEPTH-entry, LANES-lane 1R1W register file with a zeroing clear FSM.
// Define SPU_KRF_WR_BYPASS_EN to forward write data to a same-address read; otherwise reads see old data.
module spu_krf_1r1w_param
  import spu_krf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES = DEF_LANES,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                    l2clk,
  input  logic                    reset,
  input  logic                    tcu_array_wr_inhibit,
  input  logic                    clr_req,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  input  logic [LANES-1:0]        wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANE_W-1:0]       wr_data,
  output logic [LANES*LANE_W-1:0] rd_data,
  output logic                    rd_vld,
  output logic                    busy
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
  krf_state_e r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic r_rd_vld;
  logic w_idle_ok, w_rd_acc, w_wr_ok, w_clr_we;
  logic [LANES-1:0][LANE_W-1:0] w_q;
  assign busy = r_state == ST_CLEAR;
  assign rd_vld = r_rd_vld;
  assign w_idle_ok = r_state == ST_IDLE && !clr_req && !tcu_array_wr_inhibit;
  assign w_rd_acc = w_idle_ok && rd_en;
  assign w_wr_ok = w_idle_ok && ({1'b0, wr_addr} < DEPTH_W);
  assign w_clr_we = busy && !tcu_array_wr_inhibit;
  // state and clear-counter register
  always_ff @(posedge l2clk)
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  // next state: clr_req (re)starts the sweep, inhibit freezes it, last entry returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == ST_IDLE) begin
      if (clr_req) begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt = '0;
      end
    end else if (clr_req) begin
      w_cnt_nxt = '0;
    end else if (!tcu_array_wr_inhibit) begin
      w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      w_state_nxt = (r_cnt == LAST) ? ST_IDLE : ST_CLEAR;
    end
  end
  // read-valid flag, one cycle after an accepted read
  always_ff @(posedge l2clk)
    if (reset) r_rd_vld <= 1'b0;
    else r_rd_vld <= w_rd_acc;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    spu_krf_lane #(.DEPTH(DEPTH), .LANE_W(LANE_W), .AW(AW)) u_lane (
      .clk(l2clk),
      .rst(reset),
      .i_we(w_clr_we || (w_wr_ok && wr_en[k])),
      .i_waddr(busy ? r_cnt : wr_addr),
      .i_wdata(busy ? {LANE_W{KRF_PRECHARGE}} : wr_data),
      .i_re(w_rd_acc),
      .i_raddr(rd_addr),
      .o_q(w_q[k])
    );
  end
`ifdef SPU_KRF_WR_BYPASS_EN
  logic [LANES-1:0] r_byp;
  logic [LANE_W-1:0] r_byp_data;
  // remember which lanes collided so their fresh write data replaces the stale array read
  always_ff @(posedge l2clk)
    if (reset) begin
      r_byp <= '0;
      r_byp_data <= '0;
    end else begin
      r_byp <= {LANES{w_rd_acc && w_wr_ok && rd_addr == wr_addr}} & wr_en;
      r_byp_data <= wr_data;
    end
  for (genvar k = 0; k < LANES; k++) begin : g_byp
    assign rd_data[k*LANE_W +: LANE_W] = r_byp[k] ? r_byp_data : w_q[k];
  end
`else
  assign rd_data = w_q;
`endif
endmodule

// File: tb/tb_spu_krf_1r1w_param.sv
// tb_spu_krf_1r1w_param: DEPTH=16 and DEPTH=12 instances checked every cycle against an array model plus literal expectations
module tb_spu_krf_1r1w_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, inh = 1'b0, clr_req = 1'b0, rd_en = 1'b0;
  logic [3:0] rd_addr = '0, wr_addr = '0;
  logic [1:0] wr_en = '0;
  logic [63:0] wr_data = '0;
  logic [127:0] rd16, rd12;
  logic vld16, vld12, busy16, busy12;
  spu_krf_1r1w_param #(.DEPTH(16), .LANE_W(64), .LANES(2)) u16 (
    .l2clk(clk), .reset(reset), .tcu_array_wr_inhibit(inh), .clr_req(clr_req),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd16), .rd_vld(vld16), .busy(busy16));
  spu_krf_1r1w_param #(.DEPTH(12), .LANE_W(64), .LANES(2)) u12 (
    .l2clk(clk), .reset(reset), .tcu_array_wr_inhibit(inh), .clr_req(clr_req),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd12), .rd_vld(vld12), .busy(busy12));
  int checks = 0, errors = 0;
  bit started = 1'b0;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask
  int m_depth [2] = '{16, 12};
  logic [63:0] m_mem [2][64][2];
  bit m_clr [2];
  int m_cnt [2];
  logic m_vld [2];
  logic [127:0] m_rd [2];
  initial
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) begin
        m_mem[i][j][0] = '0;
        m_mem[i][j][1] = '0;
      end
  task automatic model_step(input int i);
    m_vld[i] = 1'b0;
    m_rd[i] = '0;
    if (reset) begin
      m_clr[i] = 1'b1;
      m_cnt[i] = 0;
    end else if (m_clr[i]) begin
      if (!inh) begin
        m_mem[i][m_cnt[i]][0] = '0;
        m_mem[i][m_cnt[i]][1] = '0;
      end
      if (clr_req) m_cnt[i] = 0;
      else if (!inh) begin
        if (m_cnt[i] == m_depth[i] - 1) m_clr[i] = 1'b0;
        else m_cnt[i]++;
      end
    end else if (clr_req) begin
      m_clr[i] = 1'b1;
      m_cnt[i] = 0;
    end else if (!inh) begin
      if (rd_en) begin
        m_vld[i] = 1'b1;
        if (int'(rd_addr) < m_depth[i]) m_rd[i] = {m_mem[i][rd_addr][1], m_mem[i][rd_addr][0]};
      end
      if (int'(wr_addr) < m_depth[i])
        for (int k = 0; k < 2; k++)
          if (wr_en[k]) begin
`ifdef SPU_KRF_WR_BYPASS_EN
            if (rd_en && rd_addr == wr_addr) m_rd[i][k*64 +: 64] = wr_data;
`endif
            m_mem[i][wr_addr][k] = wr_data;
          end
    end
  endtask
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end
  always @(negedge clk)
    if (started) begin
      chk("vld16", {127'b0, vld16}, {127'b0, m_vld[0]});
      chk("data16", rd16, m_rd[0]);
      chk("busy16", {127'b0, busy16}, {127'b0, m_clr[0]});
      chk("vld12", {127'b0, vld12}, {127'b0, m_vld[1]});
      chk("data12", rd12, m_rd[1]);
      chk("busy12", {127'b0, busy12}, {127'b0, m_clr[1]});
    end
  task automatic cyc(input logic r, input logic [3:0] ra, input logic [1:0] we, input logic [3:0] wa,
                     input logic [63:0] wd, input logic cr, input logic ih, input logic rs);
    reset = rs; inh = ih; clr_req = cr; rd_en = r; rd_addr = ra;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
  endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd(input logic [3:0] a); cyc(1, a, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [1:0] we, input logic [3:0] a, input logic [63:0] d); cyc(0, 0, we, a, d, 0, 0, 0); endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy16 && n < 200) begin
      idle();
      n++;
    end
  endtask
  int n, m;
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    started = 1'b1;
    chk("reset_busy", {127'b0, busy16}, 128'd1);
    chk("reset_vld", {127'b0, vld16}, 128'd0);
    chk("reset_data", rd16, 128'd0);
    wait_idle(n);
    chk("reset_clear_len", 128'(n), 128'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("post_clear_vld", {127'b0, vld16}, 128'd1);
      chk("post_clear_data", rd16, 128'd0);
    end
    wr(2'b01, 3, 64'hA5A5_0000_0000_5A5A);
    rd(3);
    chk("lane0_write_data", rd16, {64'h0, 64'hA5A5_0000_0000_5A5A});
    chk("lane0_write_vld", {127'b0, vld16}, 128'd1);
    idle();
    chk("no_read_vld", {127'b0, vld16}, 128'd0);
    chk("no_read_data", rd16, 128'd0);
    wr(2'b11, 5, 64'h1111);
    cyc(1, 5, 2'b11, 5, 64'h2222, 0, 0, 0);
`ifdef SPU_KRF_WR_BYPASS_EN
    chk("collision", rd16, {64'h2222, 64'h2222});
`else
    chk("collision", rd16, {64'h1111, 64'h1111});
`endif
    rd(5);
    chk("after_collision", rd16, {64'h2222, 64'h2222});
    cyc(1, 5, 2'b11, 5, 64'h3333, 0, 1, 0);
    chk("idle_inhibit_vld", {127'b0, vld16}, 128'd0);
    rd(5);
    chk("idle_inhibit_nowrite", rd16, {64'h2222, 64'h2222});
    for (int a = 0; a < 16; a++) wr(2'(a % 4), 4'(a), 64'(a * 32'h0101_0101 + 7));
    for (int a = 0; a < 16; a++) rd(4'(a));
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) idle();
    n = 5;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2, 2'b11, 2, 64'hFFFF, 0, 1, 0);
      chk("clear_inhibit_vld", {127'b0, vld16}, 128'd0);
      n++;
    end
    wait_idle(m);
    chk("inhibit_clear_len", 128'(n + m), 128'd19);
    rd(2);
    chk("inhibit_write_ignored", rd16, 128'd0);
    wr(2'b11, 4, 64'h77);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) idle();
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    wait_idle(n);
    chk("restart_clear_len", 128'(n), 128'd16);
    rd(4);
    chk("restart_cleared", rd16, 128'd0);
    wr(2'b11, 1, 64'hBEEF);
    wr(2'b11, 13, 64'hDEAD);
    rd(1);
    chk("d12_no_alias", rd12, {64'hBEEF, 64'hBEEF});
    rd(13);
    chk("d12_oob_data", rd12, 128'd0);
    chk("d12_oob_vld", {127'b0, vld12}, 128'd1);
    chk("d16_addr13", rd16, {64'hDEAD, 64'hDEAD});
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    chk("reset_mid_vld", {127'b0, vld16}, 128'd0);
    chk("reset_mid_busy", {127'b0, busy16}, 128'd1);
    idle();
    wait_idle(n);
    chk("reset_mid_len", 128'(n + 1), 128'd16);
    rd(1);
    chk("reset_mid_cleared", rd16, 128'd0);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
